// File: rtl/memory_master_if.sv
// Request, write-beat, read-beat and BRAM pin bundle for memory_master.
// The master modport is the memory_master's view; slave is the CPU/BRAM side.
interface memory_master_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16,
  parameter int LenWidth  = 4
);
  logic                 Req_Valid;
  logic                 Req_Ready;
  logic                 Req_Write;
  logic [AddrWidth-1:0] Req_Addr;
  logic [LenWidth-1:0]  Req_Len;
  logic [DataWidth-1:0] Wr_Data;
  logic                 Wr_Valid;
  logic                 Wr_Ready;
  logic [DataWidth-1:0] Rd_Data;
  logic                 Rd_Valid;
  logic                 Rd_Last;
  logic                 Busy;
  logic [AddrWidth-1:0] Mem_Address;
  logic [DataWidth-1:0] Mem_DIn;
  logic [DataWidth-1:0] Mem_DOut;
  logic                 Mem_Write_EN;
  logic                 Mem_En;

  modport master (
    input  Req_Valid, Req_Write, Req_Addr, Req_Len, Wr_Data, Wr_Valid, Mem_DOut,
    output Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Rd_Last, Busy,
           Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En
  );

  modport slave (
    output Req_Valid, Req_Write, Req_Addr, Req_Len, Wr_Data, Wr_Valid, Mem_DOut,
    input  Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Rd_Last, Busy,
           Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En
  );
endinterface

// File: rtl/memory_master.sv
// Burst initiator for a 256x16 single-port BRAM that samples on the negedge.
// Every BRAM-facing pin is a posedge register so it is stable at the BRAM edge.
module memory_master #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16,
  parameter int LenWidth  = 4
) (
  input logic           Clk,
  input logic           Reset,
  memory_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DRAIN,
    WR_BURST,
    WR_FLUSH
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] din_q;
  logic [DataWidth-1:0] rd_data_q;
  logic [LenWidth-1:0]  cnt_q;
  logic                 mem_en_n_q;
  logic                 mem_we_n_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic                 first_q;

  logic [AddrWidth-1:0] addr_inc_d;
  logic [LenWidth-1:0]  cnt_dec_d;
  logic                 cnt_zero_d;

  assign addr_inc_d = addr_q + AddrWidth'(1);
  assign cnt_dec_d  = cnt_q - LenWidth'(1);
  assign cnt_zero_d = (cnt_q == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      mem_en_n_q <= 1'b1;
      mem_we_n_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          if (bus.Req_Valid) begin
            addr_q     <= bus.Req_Addr;
            cnt_q      <= bus.Req_Len;
            first_q    <= 1'b1;
            mem_we_n_q <= 1'b1;
            if (bus.Req_Write) begin
              mem_en_n_q <= 1'b1;
              state_q    <= WR_BURST;
            end else begin
              mem_en_n_q <= 1'b0;
              state_q    <= RD_BURST;
            end
          end
        end

        // Capture the word the BRAM produced at the mid-cycle negedge.
        RD_BURST: begin
          rd_data_q  <= bus.Mem_DOut;
          rd_valid_q <= 1'b1;
          rd_last_q  <= cnt_zero_d;
          if (!cnt_zero_d) begin
            addr_q <= addr_inc_d;
            cnt_q  <= cnt_dec_d;
          end else begin
            mem_en_n_q <= 1'b1;
            state_q    <= RD_DRAIN;
          end
        end

        RD_DRAIN: begin
          rd_valid_q <= 1'b0;
          rd_last_q  <= 1'b0;
          state_q    <= IDLE;
        end

        // Beat 0 reuses the request address; later beats step by one.
        WR_BURST: begin
          if (bus.Wr_Valid) begin
            din_q      <= bus.Wr_Data;
            mem_en_n_q <= 1'b0;
            mem_we_n_q <= 1'b0;
            first_q    <= 1'b0;
            if (!first_q) begin
              addr_q <= addr_inc_d;
            end
            if (cnt_zero_d) begin
              state_q <= WR_FLUSH;
            end else begin
              cnt_q <= cnt_dec_d;
            end
          end else begin
            mem_en_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
          end
        end

        WR_FLUSH: begin
          mem_en_n_q <= 1'b1;
          mem_we_n_q <= 1'b1;
          state_q    <= IDLE;
        end

        default: begin
          mem_en_n_q <= 1'b1;
          mem_we_n_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.Req_Ready    = (state_q == IDLE);
  assign bus.Wr_Ready     = (state_q == WR_BURST);
  assign bus.Busy         = (state_q != IDLE);
  assign bus.Rd_Data      = rd_data_q;
  assign bus.Rd_Valid     = rd_valid_q;
  assign bus.Rd_Last      = rd_last_q;
  assign bus.Mem_Address  = addr_q;
  assign bus.Mem_DIn      = din_q;
  assign bus.Mem_Write_EN = mem_we_n_q;
  assign bus.Mem_En       = mem_en_n_q;

endmodule

// File: tb/tb_memory_master.sv
// Randomised bench for memory_master: behavioural BRAM plus an array-based
// reference memory that predicts read data, write targets and beat timing.
module tb_memory_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LW = 4;

  logic Clk = 1'b0;
  logic Reset;

  memory_master_if #(.AddrWidth(AW), .DataWidth(DW), .LenWidth(LW)) bus ();

  memory_master #(.AddrWidth(AW), .DataWidth(DW), .LenWidth(LW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0]    bram [256];
  logic [DW-1:0]    bram_dout = '0;
  logic [DW-1:0]    ref_mem [256];
  logic [AW+DW-1:0] wr_log [$];
  logic [DW-1:0]    wdat [16];
  int               wstall [16];
  int               checks = 0;
  int               errors = 0;
  int               en_low = 0;

  assign bus.Mem_DOut = bram_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // BRAM model: acts on the negedge with active-low enables.
  always @(negedge Clk) begin
    chk("we_without_en", {31'b0, (bus.Mem_Write_EN === 1'b0) && (bus.Mem_En !== 1'b0)}, 0);
    if (bus.Mem_En === 1'b0) begin
      en_low++;
      if (bus.Mem_Write_EN === 1'b0) begin
        bram[bus.Mem_Address] <= bus.Mem_DIn;
        wr_log.push_back({bus.Mem_Address, bus.Mem_DIn});
      end else begin
        bram_dout <= bram[bus.Mem_Address];
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.Req_Ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    chk("idle_wait", {31'b0, bus.Req_Ready}, 1);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    wait_idle();
    bus.Req_Valid = 1'b1;
    bus.Req_Write = wr;
    bus.Req_Addr  = a;
    bus.Req_Len   = l;
    step();
    bus.Req_Valid = 1'b0;
  endtask

  // Called right after the acceptance edge of a read.
  task automatic collect_read(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] ad;
    int n   = int'(l) + 1;
    int en0 = en_low;
    for (int k = 0; k < n; k++) begin
      ad = a + AW'(k);
      exp_q.push_back(ref_mem[ad]);
    end
    chk("rd_acc_busy", bus.Busy, 1);
    chk("rd_acc_en", bus.Mem_En, 0);
    chk("rd_acc_we", bus.Mem_Write_EN, 1);
    chk("rd_acc_addr", bus.Mem_Address, a);
    chk("rd_acc_vld", bus.Rd_Valid, 0);
    for (int k = 0; k < n; k++) begin
      step();
      ad = a + AW'((k + 1 < n) ? k + 1 : k);
      chk("rd_vld", bus.Rd_Valid, 1);
      chk("rd_data", bus.Rd_Data, exp_q[k]);
      chk("rd_last", bus.Rd_Last, (k == n - 1) ? 1 : 0);
      chk("rd_req_rdy", bus.Req_Ready, 0);
      chk("rd_addr", bus.Mem_Address, ad);
      chk("rd_en", bus.Mem_En, (k == n - 1) ? 1 : 0);
    end
    step();
    chk("rd_end_vld", bus.Rd_Valid, 0);
    chk("rd_end_last", bus.Rd_Last, 0);
    chk("rd_end_busy", bus.Busy, 0);
    chk("rd_en_cycles", en_low - en0, n);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] ad;
    int n = int'(l) + 1;
    int en0;
    wr_log.delete();
    issue(1'b1, a, l);
    en0 = en_low;
    chk("wr_acc_busy", bus.Busy, 1);
    chk("wr_acc_en", bus.Mem_En, 1);
    chk("wr_acc_addr", bus.Mem_Address, a);
    chk("wr_acc_rdy", bus.Req_Ready, 0);
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < wstall[k]; s++) begin
        bus.Wr_Valid = 1'b0;
        bus.Wr_Data  = DW'($urandom);
        step();
        ad = (k == 0) ? a : a + AW'(k - 1);
        chk("wr_stall_en", bus.Mem_En, 1);
        chk("wr_stall_we", bus.Mem_Write_EN, 1);
        chk("wr_stall_addr", bus.Mem_Address, ad);
      end
      chk("wr_ready", bus.Wr_Ready, 1);
      bus.Wr_Valid = 1'b1;
      bus.Wr_Data  = wdat[k];
      step();
      ad = a + AW'(k);
      ref_mem[ad] = wdat[k];
      chk("wr_en", bus.Mem_En, 0);
      chk("wr_we", bus.Mem_Write_EN, 0);
      chk("wr_addr", bus.Mem_Address, ad);
      chk("wr_din", bus.Mem_DIn, wdat[k]);
    end
    bus.Wr_Valid = 1'b0;
    chk("wr_flush_rdy", bus.Wr_Ready, 0);
    chk("wr_flush_busy", bus.Busy, 1);
    step();
    chk("wr_end_busy", bus.Busy, 0);
    chk("wr_end_en", bus.Mem_En, 1);
    chk("wr_end_we", bus.Mem_Write_EN, 1);
    chk("wr_count", wr_log.size(), n);
    for (int k = 0; k < n && k < wr_log.size(); k++) begin
      ad = a + AW'(k);
      chk("wr_log", {8'b0, wr_log[k]}, {8'b0, ad, wdat[k]});
    end
    chk("wr_en_cycles", en_low - en0, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int            mm;

    Reset         = 1'b1;
    bus.Req_Valid = 1'b0;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = '0;
    bus.Req_Len   = '0;
    bus.Wr_Valid  = 1'b0;
    bus.Wr_Data   = '0;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      bram[i]    = v;
      ref_mem[i] = v;
    end
    bram[5]    = 16'hBEEF;
    ref_mem[5] = 16'hBEEF;

    repeat (3) step();
    chk("rst_en", bus.Mem_En, 1);
    chk("rst_we", bus.Mem_Write_EN, 1);
    chk("rst_addr", bus.Mem_Address, 0);
    chk("rst_din", bus.Mem_DIn, 0);
    chk("rst_rdata", bus.Rd_Data, 0);
    chk("rst_rvld", bus.Rd_Valid, 0);
    chk("rst_rlast", bus.Rd_Last, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_wrdy", bus.Wr_Ready, 0);
    Reset = 1'b0;
    step();
    chk("rst_req_rdy", bus.Req_Ready, 1);

    // Single read of the preloaded word.
    issue(1'b0, 8'h05, 4'd0);
    collect_read(8'h05, 4'd0);

    // Wrapping write burst and its read-back.
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
    for (int k = 0; k < 16; k++) wstall[k] = 0;
    do_write(8'hFE, 4'd3);
    chk("wrap_mem_ff", bram[8'hFF], 16'h2222);
    chk("wrap_mem_00", bram[8'h00], 16'h3333);
    issue(1'b0, 8'hFE, 4'd3);
    collect_read(8'hFE, 4'd3);

    // Write with a three-cycle stall between the two beats.
    wdat[0] = DW'($urandom); wdat[1] = DW'($urandom);
    wstall[1] = 3;
    do_write(8'h30, 4'd1);
    wstall[1] = 0;

    // Reset during the fourth access cycle of a 16-beat read.
    issue(1'b0, 8'h40, 4'd15);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstmid_vld", bus.Rd_Valid, 1);
      chk("rstmid_data", bus.Rd_Data, ref_mem[8'h40 + AW'(k)]);
    end
    Reset = 1'b1;
    step();
    chk("rstmid_en", bus.Mem_En, 1);
    chk("rstmid_we", bus.Mem_Write_EN, 1);
    chk("rstmid_vld0", bus.Rd_Valid, 0);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstpost_vld", bus.Rd_Valid, 0);
      chk("rstpost_en", bus.Mem_En, 1);
      chk("rstpost_rdy", bus.Req_Ready, 1);
    end

    // Competing request and stray write beats held during a read burst.
    wr_log.delete();
    issue(1'b0, 8'h10, 4'd3);
    bus.Req_Valid = 1'b1;
    bus.Req_Write = 1'b0;
    bus.Req_Addr  = 8'h80;
    bus.Req_Len   = 4'd0;
    bus.Wr_Valid  = 1'b1;
    bus.Wr_Data   = 16'hDEAD;
    collect_read(8'h10, 4'd3);
    step();
    bus.Req_Valid = 1'b0;
    bus.Wr_Valid  = 1'b0;
    collect_read(8'h80, 4'd0);
    chk("stray_writes", wr_log.size(), 0);

    // Random mix of reads and writes with random stalls and gaps.
    for (int t = 0; t < 30; t++) begin
      a = AW'($urandom);
      l = LW'($urandom);
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin
          wdat[k]   = DW'($urandom);
          wstall[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
        do_write(a, l);
      end else begin
        issue(1'b0, a, l);
        collect_read(a, l);
      end
    end

    mm = 0;
    for (int i = 0; i < 256; i++) if (bram[i] !== ref_mem[i]) mm++;
    chk("mem_image", mm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
